// File: rtl/ex_stage.sv
// Execute stage of the 16-bit core: operand selection with forwarding, single-cycle
// ALU, a shift-add multiplier that stalls the front end, and the EX/MEM register.
module ex_stage #(
    parameter int MUL_ITERS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en_exmem,
    input  logic        flush_exmem,
    input  logic [15:0] pcinc_ex,
    input  logic [15:0] rd1_ex,
    input  logic [15:0] rd2_ex,
    input  logic [15:0] extended_d_ex,
    input  logic [3:0]  d_ex,
    input  logic [2:0]  regwrite_adr_ex,
    input  logic [2:0]  ALUsrcA_controll,
    input  logic [2:0]  ALUsrcB_controll,
    input  logic [3:0]  ALUop,
    input  logic        main_mem_write_ex,
    input  logic        from_main_mem_ex,
    input  logic        regwrite_ex,
    input  logic        is_halt_ex,
    input  logic [1:0]  regwrite_dat_controll_ex,
    input  logic [15:0] fwd_mem,
    input  logic [15:0] fwd_wb,
    output logic [15:0] alu_result_mem,
    output logic [15:0] store_data_mem,
    output logic [15:0] pcinc_mem,
    output logic [3:0]  flags_mem,
    output logic [2:0]  regwrite_adr_mem,
    output logic [1:0]  regwrite_dat_controll_mem,
    output logic        main_mem_write_mem,
    output logic        from_main_mem_mem,
    output logic        regwrite_mem,
    output logic        is_halt_mem,
    output logic        stall_ex,
    output logic [1:0]  state_dbg
);

    localparam int CW = $clog2(MUL_ITERS);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    typedef struct packed {
        logic [15:0] alu_result;
        logic [15:0] store_data;
        logic [15:0] pcinc;
        logic [3:0]  flags;
        logic [2:0]  regwrite_adr;
        logic [1:0]  regwrite_dat_controll;
        logic        main_mem_write;
        logic        from_main_mem;
        logic        regwrite;
        logic        is_halt;
    } exmem_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    mcand_q, mcand_d;
    logic [15:0]    mplier_q, mplier_d;
    logic [31:0]    acc_q, acc_d;
    exmem_t         exmem_q, exmem_d;

    logic [15:0] op_a, op_b, alu_res, rot;
    logic [16:0] sum, diff, sll_w, srl_w, sra_w;
    logic [3:0]  sh, alu_flags;
    logic        alu_c, alu_v, alu_ok, bubble;
    exmem_t      rec;

    always_comb begin
        case (ALUsrcA_controll)
            3'd0:    op_a = rd1_ex;
            3'd1:    op_a = pcinc_ex;
            3'd2:    op_a = fwd_mem;
            3'd3:    op_a = fwd_wb;
            default: op_a = 16'h0;
        endcase
        case (ALUsrcB_controll)
            3'd0:    op_b = rd2_ex;
            3'd1:    op_b = extended_d_ex;
            3'd2:    op_b = {12'h0, d_ex};
            3'd3:    op_b = fwd_mem;
            3'd4:    op_b = fwd_wb;
            default: op_b = 16'h0;
        endcase
    end

    // Shifts carry one extra bit so the last bit shifted out falls out as the carry.
    always_comb begin
        sh      = op_b[3:0];
        sum     = {1'b0, op_a} + {1'b0, op_b};
        diff    = {1'b0, op_a} - {1'b0, op_b};
        sll_w   = {1'b0, op_a} << sh;
        srl_w   = {op_a, 1'b0} >> sh;
        sra_w   = $signed({op_a, 1'b0}) >>> sh;
        rot     = (op_a << sh) | (op_a >> (5'd16 - {1'b0, sh}));
        alu_res = 16'h0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_ok  = 1'b1;
        case (ALUop)
            4'd0: begin
                alu_res = sum[15:0];
                alu_c   = sum[16];
                alu_v   = (op_a[15] == op_b[15]) && (sum[15] != op_a[15]);
            end
            4'd1, 4'd5: begin
                alu_res = diff[15:0];
                alu_c   = diff[16];
                alu_v   = (op_a[15] != op_b[15]) && (diff[15] != op_a[15]);
            end
            4'd2:  alu_res = op_a & op_b;
            4'd3:  alu_res = op_a | op_b;
            4'd4:  alu_res = op_a ^ op_b;
            4'd6:  alu_res = op_b;
            4'd8:  begin alu_res = sll_w[15:0];  alu_c = sll_w[16]; end
            4'd9:  begin alu_res = rot;          alu_c = (sh != 4'h0) && rot[0]; end
            4'd10: begin alu_res = srl_w[16:1];  alu_c = srl_w[0]; end
            4'd11: begin alu_res = sra_w[16:1];  alu_c = sra_w[0]; end
            default: alu_ok = 1'b0;
        endcase
        alu_flags = alu_ok ? {alu_res[15], alu_res == 16'h0, alu_c, alu_v} : 4'h0;
    end

    // stall_ex=1 means ID/EX must hold its current instruction; EX/MEM accepts
    // a new entry only on edges where en_exmem=1.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        stall_ex = 1'b0;
        bubble   = 1'b0;

        rec.alu_result            = alu_res;
        rec.store_data            = rd2_ex;
        rec.pcinc                 = pcinc_ex;
        rec.flags                 = alu_flags;
        rec.regwrite_adr          = regwrite_adr_ex;
        rec.regwrite_dat_controll = regwrite_dat_controll_ex;
        rec.main_mem_write        = main_mem_write_ex;
        rec.from_main_mem         = from_main_mem_ex;
        rec.regwrite              = regwrite_ex;
        rec.is_halt               = is_halt_ex;

        case (state_q)
            IDLE: begin
                if (ALUop == 4'd12) begin
                    state_d  = BUSY;
                    mcand_d  = {16'h0, op_a};
                    mplier_d = op_b;
                    acc_d    = 32'h0;
                    cnt_d    = '0;
                    stall_ex = 1'b1;
                    bubble   = 1'b1;
                end
            end
            BUSY: begin
                stall_ex = 1'b1;
                bubble   = 1'b1;
                if (mplier_q[0]) acc_d = acc_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(MUL_ITERS - 1)) state_d = DONE;
            end
            DONE: begin
                rec.alu_result = acc_q[15:0];
                rec.flags      = {acc_q[15], acc_q[15:0] == 16'h0, acc_q[31:16] != 16'h0, 1'b0};
                if (en_exmem) state_d = IDLE;
                else          stall_ex = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        exmem_d = exmem_q;
        if (flush_exmem)   exmem_d = '0;
        else if (en_exmem) exmem_d = bubble ? '0 : rec;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= 32'h0;
            mplier_q <= 16'h0;
            acc_q    <= 32'h0;
            exmem_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            exmem_q  <= exmem_d;
        end
    end

    assign alu_result_mem            = exmem_q.alu_result;
    assign store_data_mem            = exmem_q.store_data;
    assign pcinc_mem                 = exmem_q.pcinc;
    assign flags_mem                 = exmem_q.flags;
    assign regwrite_adr_mem          = exmem_q.regwrite_adr;
    assign regwrite_dat_controll_mem = exmem_q.regwrite_dat_controll;
    assign main_mem_write_mem        = exmem_q.main_mem_write;
    assign from_main_mem_mem         = exmem_q.from_main_mem;
    assign regwrite_mem              = exmem_q.regwrite;
    assign is_halt_mem               = exmem_q.is_halt;
    assign state_dbg                 = state_q;

endmodule
